// File: rtl/alu_result_checker.sv
// alu_result_checker
// Checks a stream of ALU samples (op, A, B, result, zero) against a reference
// add/AND model and keeps pass/fail statistics for one run of num_vec vectors.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, num_vec       begin a run of num_vec vectors (ignored while running)
//   in_valid / in_ready  sample handshake; a sample is taken when both are 1
//   op, A, B             operation (0 = add, 1 = AND) and operands
//   result, zero         ALU outputs under test
//   chk_valid, chk_pass  registered one-cycle result of each comparison
//   pass_cnt, fail_cnt   saturating pass/fail counters
//   fail_idx             0-based index of the first failing vector
//   done, all_pass       run complete / run complete with no failures
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until num_vec have been taken and checked
// DONE  | run finished, results held until next start
module alu_result_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] result,
    input  logic             zero,
    output logic             chk_valid,
    output logic             chk_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic             done,
    output logic             all_pass
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] rem_cnt;      // vectors still to be accepted (down-counter)
    logic [CNT_W-1:0] vec_idx;
    logic [WIDTH-1:0] exp_val;
    logic             exp_zero;
    logic             match;
    logic             accept;
    logic             start_acc;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign in_ready  = (state == RUN) && (rem_cnt != '0);
    assign accept    = in_valid && in_ready;
    assign start_acc = start && (state != RUN);
    assign vec_idx   = num_lat - rem_cnt;

    always_comb begin
        exp_val = '0;
        if (op) exp_val = A & B;
        else    exp_val = A + B;
    end

    assign exp_zero = (exp_val == '0);
    assign match    = (result == exp_val) && (zero == exp_zero);

    assign done     = (state == DONE);
    assign all_pass = done && (fail_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // rem_cnt reaches zero on the same edge that registers the last chk_valid,
    // so RUN with rem_cnt == 0 is exactly the cycle of that final pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (rem_cnt == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_lat   <= '0;
            rem_cnt   <= '0;
            chk_valid <= 1'b0;
            chk_pass  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
        end else begin
            chk_valid <= accept;
            chk_pass  <= accept && match;
            if (start_acc) begin
                num_lat  <= num_vec;
                rem_cnt  <= num_vec;
                pass_cnt <= '0;
                fail_cnt <= '0;
                fail_idx <= '0;
            end else if (accept) begin
                rem_cnt <= rem_cnt - 1'b1;
                if (match) begin
                    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    // fail_cnt never returns to zero within a run, so it marks
                    // whether the first failure has been seen.
                    if (fail_cnt == '0) fail_idx <= vec_idx;
                    if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] A, B, result;
    logic             zero;
    logic             chk_valid, chk_pass;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, fail_idx;
    logic             done, all_pass;

    int checks = 0;
    int errors = 0;

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .A(A), .B(B),
        .result(result), .zero(zero), .chk_valid(chk_valid), .chk_pass(chk_pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_idx(fail_idx),
        .done(done), .all_pass(all_pass)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1; num_vec = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] r, input logic z);
        in_valid = 1'b1; op = o; A = a; B = b; result = r; zero = z;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 0; num_vec = 0; in_valid = 0; op = 0; A = 0; B = 0; result = 0; zero = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, chk_valid, chk_pass, done, all_pass} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 00000", {in_ready, chk_valid, chk_pass, done, all_pass});
        end
        checks++;
        if ({pass_cnt, fail_cnt, fail_idx} !== 24'h0) begin
            errors++; $display("FAIL reset_counters: got %h want 000000", {pass_cnt, fail_cnt, fail_idx});
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, done} !== 2'b00) begin
            errors++; $display("FAIL idle_wait: got %b want 00", {in_ready, done});
        end
    endtask

    task automatic test_add;
        do_start(3);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
        drive(0, 4'd0, 4'd0, 4'd0, 1'b1);
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11) begin errors++; $display("FAIL add_v0: got %b want 11", {chk_valid, chk_pass}); end
        drive(0, 4'd5, 4'd3, 4'd8, 1'b0);
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11) begin errors++; $display("FAIL add_v1: got %b want 11", {chk_valid, chk_pass}); end
        drive(0, 4'd15, 4'd1, 4'd0, 1'b1);
        in_valid = 1'b0;
        checks++;
        if ({chk_valid, chk_pass, in_ready, done} !== 4'b1100) begin
            errors++; $display("FAIL add_wrap: got %b want 1100", {chk_valid, chk_pass, in_ready, done});
        end
        @(posedge clk); #1;
        checks++;
        if ({done, all_pass} !== 2'b11 || pass_cnt !== 8'd3 || fail_cnt !== 8'd0 || fail_idx !== 8'd0) begin
            errors++; $display("FAIL add_done: got done=%b all_pass=%b pass=%0d fail=%0d idx=%0d want 1 1 3 0 0",
                               done, all_pass, pass_cnt, fail_cnt, fail_idx);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({done, all_pass, chk_valid} !== 3'b110) begin
            errors++; $display("FAIL done_hold: got %b want 110", {done, all_pass, chk_valid});
        end
    endtask

    task automatic test_and;
        do_start(2);
        checks++;
        if ({done, pass_cnt} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL and_restart: got done=%b pass=%0d want 0 0", done, pass_cnt);
        end
        drive(1, 4'd5, 4'd3, 4'd1, 1'b0);
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11) begin errors++; $display("FAIL and_v0: got %b want 11", {chk_valid, chk_pass}); end
        drive(1, 4'd0, 4'd15, 4'd0, 1'b1);
        in_valid = 1'b0;
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11) begin errors++; $display("FAIL and_v1: got %b want 11", {chk_valid, chk_pass}); end
        @(posedge clk); #1;
        checks++;
        if ({done, all_pass} !== 2'b11 || pass_cnt !== 8'd2) begin
            errors++; $display("FAIL and_done: got done=%b all_pass=%b pass=%0d want 1 1 2", done, all_pass, pass_cnt);
        end
    endtask

    task automatic test_errors;
        do_start(3);
        drive(0, 4'd1, 4'd2, 4'd3, 1'b0);
        checks++;
        if ({chk_valid, chk_pass} !== 2'b11) begin errors++; $display("FAIL err_v0: got %b want 11", {chk_valid, chk_pass}); end
        drive(0, 4'd5, 4'd3, 4'd8, 1'b1);
        checks++;
        if ({chk_valid, chk_pass, fail_idx} !== {2'b10, 8'd1}) begin
            errors++; $display("FAIL err_v1: got v=%b p=%b idx=%0d want 1 0 1", chk_valid, chk_pass, fail_idx);
        end
        drive(1, 4'd5, 4'd3, 4'd7, 1'b0);
        in_valid = 1'b0;
        checks++;
        if ({chk_valid, chk_pass, fail_idx} !== {2'b10, 8'd1}) begin
            errors++; $display("FAIL err_v2: got v=%b p=%b idx=%0d want 1 0 1", chk_valid, chk_pass, fail_idx);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, all_pass} !== 2'b10 || pass_cnt !== 8'd1 || fail_cnt !== 8'd2 || fail_idx !== 8'd1) begin
            errors++; $display("FAIL err_done: got done=%b all_pass=%b pass=%0d fail=%0d idx=%0d want 1 0 1 2 1",
                               done, all_pass, pass_cnt, fail_cnt, fail_idx);
        end
        // in_valid in DONE must not disturb the counters
        drive(0, 4'd1, 4'd1, 4'd7, 1'b0);
        drive(0, 4'd1, 4'd1, 4'd2, 1'b0);
        in_valid = 1'b0;
        checks++;
        if (chk_valid !== 1'b0 || pass_cnt !== 8'd1 || fail_cnt !== 8'd2) begin
            errors++; $display("FAIL done_ignore: got v=%b pass=%0d fail=%0d want 0 1 2", chk_valid, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int acc = 0;
        logic [5:0] cv = '0;
        do_start(4);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; op = 1'b0; A = 4'(k); B = 4'(k); result = 4'(2 * k); zero = (k == 0);
            // a start mid-run must not restart the run
            start = (k == 2); num_vec = 8'd0;
            #0;
            if (in_ready) acc++;
            @(posedge clk); #1;
            cv[k] = chk_valid;
        end
        in_valid = 1'b0; start = 1'b0;
        checks++;
        if (acc !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", acc); end
        checks++;
        if (cv !== 6'b001111) begin errors++; $display("FAIL b2b_chk_pulses: got %b want 001111", cv); end
        checks++;
        if ({in_ready, done, all_pass} !== 3'b011 || pass_cnt !== 8'd4) begin
            errors++; $display("FAIL b2b_end: got ready=%b done=%b all_pass=%b pass=%0d want 0 1 1 4",
                               in_ready, done, all_pass, pass_cnt);
        end
    endtask

    task automatic test_empty;
        do_start(0);
        checks++;
        if ({done, pass_cnt, fail_cnt} !== {1'b0, 16'h0}) begin
            errors++; $display("FAIL empty_run: got done=%b pass=%0d fail=%0d want 0 0 0", done, pass_cnt, fail_cnt);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if ({done, all_pass, chk_valid} !== 3'b110 || pass_cnt !== 8'd0 || fail_cnt !== 8'd0) begin
            errors++; $display("FAIL empty_done: got done=%b all_pass=%b v=%b pass=%0d fail=%0d want 1 1 0 0 0",
                               done, all_pass, chk_valid, pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int late = 0;
        do_start(5);
        drive(0, 4'd1, 4'd1, 4'd2, 1'b0);
        drive(0, 4'd2, 4'd2, 4'd4, 1'b0);
        drive(0, 4'd3, 4'd3, 4'd0, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, chk_valid, chk_pass, done, all_pass} !== 5'b0 || {pass_cnt, fail_cnt, fail_idx} !== 24'h0) begin
            errors++; $display("FAIL mid_reset: got flags=%b cnt=%h want 00000 000000",
                               {in_ready, chk_valid, chk_pass, done, all_pass}, {pass_cnt, fail_cnt, fail_idx});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (chk_valid || in_ready || done) late++;
        end
        in_valid = 1'b0;
        checks++;
        if (late !== 0) begin errors++; $display("FAIL mid_after_release: got %0d active cycles want 0", late); end
        do_start(2);
        drive(1, 4'd6, 4'd3, 4'd2, 1'b0);
        drive(0, 4'd9, 4'd7, 4'd0, 1'b1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({done, all_pass} !== 2'b11 || pass_cnt !== 8'd2 || fail_cnt !== 8'd0 || fail_idx !== 8'd0) begin
            errors++; $display("FAIL mid_rerun: got done=%b all_pass=%b pass=%0d fail=%0d idx=%0d want 1 1 2 0 0",
                               done, all_pass, pass_cnt, fail_cnt, fail_idx);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_and();
        test_errors();
        test_back_to_back();
        test_empty();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
